cpu_mem_arbiter: RTL and testbench
==================================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1: on simultaneous request with no fairness override, data port wins; 0 = fetch wins.
REQ-002 SHALL have port i_clock, in, 1: sole clock; all state on rising edge.
REQ-003 SHALL have port i_reset, in, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_fetch_request, in, 1: fetch wants a word read; held until o_fetch_ready.
REQ-005 SHALL have port i_fetch_address, in, 32: fetch byte address, stable while requesting.
REQ-006 SHALL have port o_fetch_ready, out, 1: one-cycle completion pulse for fetch.
REQ-007 SHALL have port o_fetch_data, out, 32: fetched word, valid with o_fetch_ready, held until next fetch completes.
REQ-008 SHALL have port i_data_request, in, 1: load/store request from execute stage; held until o_data_ready.
REQ-009 SHALL have port i_data_rw, in, 1: 1 = write, 0 = read.
REQ-010 SHALL have port i_data_width, in, 3: 1 byte, 2 half, 4 word; other codes are an error.
REQ-011 SHALL have port i_data_signed, in, 1: sign-extend sub-word reads.
REQ-012 SHALL have port i_data_address, in, 32: data byte address.
REQ-013 SHALL have port i_data_wdata, in, 32: write data, right-aligned (lowest byte/half).
REQ-014 SHALL have port o_data_ready, out, 1: one-cycle completion pulse for data.
REQ-015 SHALL have port o_data_rdata, out, 32: aligned, extended read result, valid with o_data_ready.
REQ-016 SHALL have port o_data_error, out, 1: pulses with o_data_ready on misalignment or bad width.
REQ-017 SHALL have port o_bus_request, out, 1: bus transaction active; held until i_bus_ready.
REQ-018 SHALL have port o_bus_rw, out, 1: bus write when 1.
REQ-019 SHALL have port o_bus_address, out, 32: word address, bits [1:0] always 0.
REQ-020 SHALL have port o_bus_wdata, out, 32: full word to write.
REQ-021 SHALL have port i_bus_ready, in, 1: one-cycle completion from bus; i_bus_rdata valid same cycle.
REQ-022 SHALL have port i_bus_rdata, in, 32: bus read word.

Function
REQ-023 SHALL implement states IDLE, FETCH, DREAD, RMW_READ, RMW_WRITE, DWRITE, DONE.
REQ-024 SHALL in IDLE grant one requester per cycle; bus request asserted the cycle after grant (registered outputs).
REQ-025 SHALL override DATA_FIRST fairness: after a data grant with fetch waiting, next contested grant goes to fetch, and vice versa.
REQ-026 SHALL check data alignment at grant: half needs addr[0]=0, word needs addr[1:0]=0; failure -> DONE with o_data_error=1, no bus access.
REQ-027 SHALL route fetch and data reads (any width) as one word read; DWRITE for word writes only.
REQ-028 SHALL perform byte/half writes as read-modify-write: RMW_READ, merge wdata into lane selected by addr[1:0] (little-endian), RMW_WRITE.
REQ-029 SHALL extract read lanes by addr[1:0], zero- or sign-extend per i_data_signed.
REQ-030 SHALL in DONE pulse exactly one ready for the served port, then return to IDLE; same-port re-grant earliest the cycle after DONE.
REQ-031 SHALL ignore i_bus_ready when o_bus_request is low; drop o_bus_request the cycle after i_bus_ready.
REQ-032 SHALL never lose a request: a request arriving during a transaction is served after it returns to IDLE.
REQ-033 SHALL latch address, width, sign, rw, wdata at grant; requester changes mid-transaction have no effect.

Reset
REQ-034 SHALL on i_reset low immediately force IDLE, all ready/error/bus outputs 0, data outputs 0, fairness to DATA_FIRST; in-flight transaction abandoned without completion pulse.
REQ-035 SHALL resume granting on first rising edge after i_reset goes high.

Structure
REQ-036 SHALL place state encoding and width codes (1/2/4) in shared package cpu_mem_pkg.
REQ-037 SHALL use one sub-module cpu_mem_lane (combinational lane extract/sign-extend and write merge).
REQ-038 SHALL keep FSM and arbitration in cpu_mem_arbiter only.

Verification
REQ-039 SHALL test: fetch 0x100 only, bus returns 0xDEADBEEF after 3 cycles -> o_fetch_data=0xDEADBEEF, one ready pulse.
REQ-040 SHALL test: signed byte read 0x203, bus word 0x80112233 -> o_data_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-041 SHALL test: half write 0xABCD to 0x302, memory 0x11223344 -> bus read then bus write 0xABCD3344 at 0x300.
REQ-042 SHALL test: word read 0x401 -> o_data_error=1 with o_data_ready, zero bus requests.
REQ-043 SHALL test: fetch and data held together for 4 transactions -> grants alternate data, fetch, data, fetch.
REQ-044 SHALL test: reset low during RMW_READ -> outputs 0 at once, no ready pulse, clean word read after release.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory arbiter: FSM state encoding, access-width codes and
// the alignment rule applied when a data request is granted.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDread,
    StRmwRead,
    StRmwWrite,
    StDwrite,
    StDone
  } state_e;

  localparam logic [2:0] WidthByte = 3'd1;
  localparam logic [2:0] WidthHalf = 3'd2;
  localparam logic [2:0] WidthWord = 3'd4;

  // True when the width code is legal and the byte offset is naturally aligned for it.
  function automatic logic access_ok(input logic [2:0] width, input logic [1:0] offset);
    case (width)
      WidthByte: access_ok = 1'b1;
      WidthHalf: access_ok = ~offset[0];
      WidthWord: access_ok = (offset == 2'b00);
      default:   access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Request/response signals between the fetch port, the data port, the memory bus and the
// arbiter. The master modport is the arbiter's view; the slave modport is its environment.
interface cpu_mem_arbiter_if;
  logic        i_fetch_request;
  logic [31:0] i_fetch_address;
  logic        o_fetch_ready;
  logic [31:0] o_fetch_data;

  logic        i_data_request;
  logic        i_data_rw;
  logic [2:0]  i_data_width;
  logic        i_data_signed;
  logic [31:0] i_data_address;
  logic [31:0] i_data_wdata;
  logic        o_data_ready;
  logic [31:0] o_data_rdata;
  logic        o_data_error;

  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  modport master (
    input  i_fetch_request, i_fetch_address,
    output o_fetch_ready, o_fetch_data,
    input  i_data_request, i_data_rw, i_data_width, i_data_signed, i_data_address,
    input  i_data_wdata,
    output o_data_ready, o_data_rdata, o_data_error,
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    input  i_bus_ready, i_bus_rdata
  );

  modport slave (
    output i_fetch_request, i_fetch_address,
    input  o_fetch_ready, o_fetch_data,
    output i_data_request, i_data_rw, i_data_width, i_data_signed, i_data_address,
    output i_data_wdata,
    input  o_data_ready, o_data_rdata, o_data_error,
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    output i_bus_ready, i_bus_rdata
  );
endinterface

// File: rtl/cpu_mem_lane.sv
// Little-endian lane logic: extracts and extends a sub-word read from a bus word, and
// merges right-aligned write data into the selected lane of a bus word.
module cpu_mem_lane
  import cpu_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_width,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_mask;

  assign w_shift = {i_offset, 3'b000};
  assign w_lane  = i_word >> w_shift;

  // Word accesses are always aligned, so the shifted word equals the raw word.
  always_comb begin
    o_rdata = w_lane;
    w_mask  = 32'hFFFF_FFFF;
    case (i_width)
      WidthByte: begin
        o_rdata = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
        w_mask  = 32'h0000_00FF << w_shift;
      end
      WidthHalf: begin
        o_rdata = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
        w_mask  = 32'h0000_FFFF << w_shift;
      end
      default: ;
    endcase
    o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates instruction fetch and load/store requests onto a single word-wide memory bus,
// with alternating fairness, alignment checking and read-modify-write for sub-word stores.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input logic               i_clock,
  input logic               i_reset,
  cpu_mem_arbiter_if.master io_bus
);

  state_e      r_state, w_state_next;
  logic        r_prefer_data, w_prefer_data_next;
  logic [1:0]  r_offset, w_offset_next;
  logic [2:0]  r_width, w_width_next;
  logic        r_signed, w_signed_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic        r_fetch_ready, w_fetch_ready_next;
  logic [31:0] r_fetch_data, w_fetch_data_next;
  logic        r_data_ready, w_data_ready_next;
  logic [31:0] r_data_rdata, w_data_rdata_next;
  logic        r_data_error, w_data_error_next;
  logic        r_bus_request, w_bus_request_next;
  logic        r_bus_rw, w_bus_rw_next;
  logic [31:0] r_bus_address, w_bus_address_next;
  logic [31:0] r_bus_wdata, w_bus_wdata_next;

  logic        w_bus_done;
  logic        w_pick_data;
  logic [31:0] w_lane_rdata;
  logic [31:0] w_lane_merged;

  cpu_mem_lane u_lane (
    .i_word   (io_bus.i_bus_rdata),
    .i_offset (r_offset),
    .i_width  (r_width),
    .i_signed (r_signed),
    .i_wdata  (r_wdata),
    .o_rdata  (w_lane_rdata),
    .o_merged (w_lane_merged)
  );

  assign w_bus_done  = r_bus_request & io_bus.i_bus_ready;
  assign w_pick_data = io_bus.i_data_request & (~io_bus.i_fetch_request | r_prefer_data);

  always_comb begin
    w_state_next        = r_state;
    w_prefer_data_next  = r_prefer_data;
    w_offset_next       = r_offset;
    w_width_next        = r_width;
    w_signed_next       = r_signed;
    w_wdata_next        = r_wdata;
    w_fetch_ready_next  = 1'b0;
    w_fetch_data_next   = r_fetch_data;
    w_data_ready_next   = 1'b0;
    w_data_rdata_next   = r_data_rdata;
    w_data_error_next   = 1'b0;
    w_bus_request_next  = r_bus_request;
    w_bus_rw_next       = r_bus_rw;
    w_bus_address_next  = r_bus_address;
    w_bus_wdata_next    = r_bus_wdata;

    unique case (r_state)
      StIdle: begin
        // A contested grant hands priority to the loser for the next contest.
        if (io_bus.i_data_request && io_bus.i_fetch_request) begin
          w_prefer_data_next = ~w_pick_data;
        end
        if (w_pick_data) begin
          w_offset_next      = io_bus.i_data_address[1:0];
          w_width_next       = io_bus.i_data_width;
          w_signed_next      = io_bus.i_data_signed;
          w_wdata_next       = io_bus.i_data_wdata;
          w_bus_address_next = io_bus.i_data_address & ~32'h3;
          if (!access_ok(io_bus.i_data_width, io_bus.i_data_address[1:0])) begin
            w_state_next      = StDone;
            w_data_ready_next = 1'b1;
            w_data_error_next = 1'b1;
            w_data_rdata_next = '0;
          end else if (!io_bus.i_data_rw) begin
            w_state_next       = StDread;
            w_bus_request_next = 1'b1;
            w_bus_rw_next      = 1'b0;
          end else if (io_bus.i_data_width == WidthWord) begin
            w_state_next       = StDwrite;
            w_bus_request_next = 1'b1;
            w_bus_rw_next      = 1'b1;
            w_bus_wdata_next   = io_bus.i_data_wdata;
          end else begin
            w_state_next       = StRmwRead;
            w_bus_request_next = 1'b1;
            w_bus_rw_next      = 1'b0;
          end
        end else if (io_bus.i_fetch_request) begin
          w_state_next       = StFetch;
          w_bus_request_next = 1'b1;
          w_bus_rw_next      = 1'b0;
          w_bus_address_next = io_bus.i_fetch_address & ~32'h3;
        end
      end
      StFetch: begin
        if (w_bus_done) begin
          w_state_next       = StDone;
          w_bus_request_next = 1'b0;
          w_fetch_data_next  = io_bus.i_bus_rdata;
          w_fetch_ready_next = 1'b1;
        end
      end
      StDread: begin
        if (w_bus_done) begin
          w_state_next       = StDone;
          w_bus_request_next = 1'b0;
          w_data_rdata_next  = w_lane_rdata;
          w_data_ready_next  = 1'b1;
        end
      end
      StRmwRead: begin
        if (w_bus_done) begin
          w_state_next       = StRmwWrite;
          w_bus_request_next = 1'b0;
          w_bus_rw_next      = 1'b1;
          w_bus_wdata_next   = w_lane_merged;
        end
      end
      StRmwWrite: begin
        // The request is low for one cycle between the read and write halves.
        if (!r_bus_request) begin
          w_bus_request_next = 1'b1;
        end else if (w_bus_done) begin
          w_state_next       = StDone;
          w_bus_request_next = 1'b0;
          w_bus_rw_next      = 1'b0;
          w_data_ready_next  = 1'b1;
        end
      end
      StDwrite: begin
        if (w_bus_done) begin
          w_state_next       = StDone;
          w_bus_request_next = 1'b0;
          w_bus_rw_next      = 1'b0;
          w_data_ready_next  = 1'b1;
        end
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= StIdle;
      r_prefer_data <= DATA_FIRST;
      r_offset      <= '0;
      r_width       <= '0;
      r_signed      <= 1'b0;
      r_wdata       <= '0;
      r_fetch_ready <= 1'b0;
      r_fetch_data  <= '0;
      r_data_ready  <= 1'b0;
      r_data_rdata  <= '0;
      r_data_error  <= 1'b0;
      r_bus_request <= 1'b0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_prefer_data <= w_prefer_data_next;
      r_offset      <= w_offset_next;
      r_width       <= w_width_next;
      r_signed      <= w_signed_next;
      r_wdata       <= w_wdata_next;
      r_fetch_ready <= w_fetch_ready_next;
      r_fetch_data  <= w_fetch_data_next;
      r_data_ready  <= w_data_ready_next;
      r_data_rdata  <= w_data_rdata_next;
      r_data_error  <= w_data_error_next;
      r_bus_request <= w_bus_request_next;
      r_bus_rw      <= w_bus_rw_next;
      r_bus_address <= w_bus_address_next;
      r_bus_wdata   <= w_bus_wdata_next;
    end
  end

  assign io_bus.o_fetch_ready = r_fetch_ready;
  assign io_bus.o_fetch_data  = r_fetch_data;
  assign io_bus.o_data_ready  = r_data_ready;
  assign io_bus.o_data_rdata  = r_data_rdata;
  assign io_bus.o_data_error  = r_data_error;
  assign io_bus.o_bus_request = r_bus_request;
  assign io_bus.o_bus_rw      = r_bus_rw;
  assign io_bus.o_bus_address = r_bus_address;
  assign io_bus.o_bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a latency-configurable single-word bus model, a
// ready-pulse monitor, and one task per scenario with hand-computed expectations.
module tb_cpu_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int PortData  = 1;
  localparam int PortFetch = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if bif ();

  cpu_mem_arbiter #(.DATA_FIRST(1'b1)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .io_bus  (bif)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_word = 32'h0;
  int          bus_lat  = 1;
  int          n_bus    = 0;
  int          fetch_pulses = 0;
  int          data_pulses  = 0;
  logic [31:0] log_addr[$];
  logic        log_rw[$];
  logic [31:0] log_wdata[$];
  int          order_q[$];

  // Bus model: answers each request after bus_lat observed cycles with mem_word.
  initial begin : bus_model
    int cnt;
    cnt = 0;
    bif.i_bus_ready = 1'b0;
    bif.i_bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bif.i_bus_ready = 1'b0;
      if (!rst_n || !bif.o_bus_request) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 1) begin
          n_bus++;
          log_addr.push_back(bif.o_bus_address);
          log_rw.push_back(bif.o_bus_rw);
          log_wdata.push_back(bif.o_bus_wdata);
        end
        if (cnt >= bus_lat) begin
          bif.i_bus_ready = 1'b1;
          bif.i_bus_rdata = mem_word;
          if (bif.o_bus_rw) mem_word = bif.o_bus_wdata;
          cnt = 0;
        end
      end
    end
  end

  initial begin : ready_monitor
    forever begin
      @(negedge clk);
      if (bif.o_fetch_ready === 1'b1) begin
        fetch_pulses++;
        order_q.push_back(PortFetch);
      end
      if (bif.o_data_ready === 1'b1) begin
        data_pulses++;
        order_q.push_back(PortData);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic fetch_xfer(input logic [31:0] addr, output logic [31:0] data, output bit to);
    @(posedge clk);
    #1;
    bif.i_fetch_request = 1'b1;
    bif.i_fetch_address = addr;
    to   = 1'b1;
    data = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.o_fetch_ready === 1'b1) begin
        data = bif.o_fetch_data;
        to   = 1'b0;
        break;
      end
    end
    bif.i_fetch_request = 1'b0;
  endtask

  task automatic data_xfer(input logic rw, input logic [2:0] width, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output bit to);
    @(posedge clk);
    #1;
    bif.i_data_request = 1'b1;
    bif.i_data_rw      = rw;
    bif.i_data_width   = width;
    bif.i_data_signed  = sgn;
    bif.i_data_address = addr;
    bif.i_data_wdata   = wdata;
    to    = 1'b1;
    rdata = '0;
    err   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bif.o_data_ready === 1'b1) begin
        rdata = bif.o_data_rdata;
        err   = bif.o_data_error;
        to    = 1'b0;
        break;
      end
    end
    bif.i_data_request = 1'b0;
  endtask

  task automatic test_reset();
    bif.i_fetch_request = 1'b0;
    bif.i_fetch_address = '0;
    bif.i_data_request  = 1'b0;
    bif.i_data_rw       = 1'b0;
    bif.i_data_width    = WidthWord;
    bif.i_data_signed   = 1'b0;
    bif.i_data_address  = '0;
    bif.i_data_wdata    = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({bif.o_fetch_ready, bif.o_data_ready, bif.o_data_error, bif.o_bus_request,
         bif.o_bus_rw} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {bif.o_fetch_ready, bif.o_data_ready,
               bif.o_data_error, bif.o_bus_request, bif.o_bus_rw});
    else n_pass++;
    n_checks++;
    if ({bif.o_bus_address, bif.o_bus_wdata} !== 64'h0)
      $display("FAIL reset_bus: got %h/%h want 0/0", bif.o_bus_address, bif.o_bus_wdata);
    else n_pass++;
    n_checks++;
    if ({bif.o_fetch_data, bif.o_data_rdata} !== 64'h0)
      $display("FAIL reset_data: got %h/%h want 0/0", bif.o_fetch_data, bif.o_data_rdata);
    else n_pass++;
    wait_cycles(3);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] d;
    bit          to;
    int          f0, d0, b0;
    mem_word = 32'hDEAD_BEEF;
    bus_lat  = 3;
    f0 = fetch_pulses; d0 = data_pulses; b0 = n_bus;
    fetch_xfer(32'h100, d, to);
    n_checks++;
    if (to !== 1'b0 || d !== 32'hDEAD_BEEF)
      $display("FAIL fetch_data: got %h (timeout %0b) want deadbeef", d, to);
    else n_pass++;
    wait_cycles(4);
    n_checks++;
    if (fetch_pulses - f0 !== 1 || data_pulses - d0 !== 0)
      $display("FAIL fetch_pulses: got fetch %0d data %0d want 1 0",
               fetch_pulses - f0, data_pulses - d0);
    else n_pass++;
    n_checks++;
    if (n_bus - b0 !== 1 || log_addr[b0] !== 32'h100 || log_rw[b0] !== 1'b0)
      $display("FAIL fetch_bus: got %0d txns addr %h rw %b want 1 00000100 0",
               n_bus - b0, log_addr[b0], log_rw[b0]);
    else n_pass++;
    n_checks++;
    if (bif.o_fetch_data !== 32'hDEAD_BEEF || bif.o_bus_request !== 1'b0)
      $display("FAIL fetch_hold: got data %h req %b want deadbeef 0",
               bif.o_fetch_data, bif.o_bus_request);
    else n_pass++;
  endtask

  task automatic test_byte_read();
    logic [31:0] rd;
    logic        er;
    bit          to;
    mem_word = 32'h8011_2233;
    bus_lat  = 1;
    data_xfer(1'b0, WidthByte, 1'b1, 32'h203, 32'h0, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || rd !== 32'hFFFF_FF80 || er !== 1'b0)
      $display("FAIL byte_signed: got %h err %b (timeout %0b) want ffffff80 0", rd, er, to);
    else n_pass++;
    n_checks++;
    if (log_addr[n_bus-1] !== 32'h200)
      $display("FAIL byte_bus_addr: got %h want 00000200", log_addr[n_bus-1]);
    else n_pass++;
    data_xfer(1'b0, WidthByte, 1'b0, 32'h203, 32'h0, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || rd !== 32'h0000_0080)
      $display("FAIL byte_unsigned: got %h (timeout %0b) want 00000080", rd, to);
    else n_pass++;
    data_xfer(1'b0, WidthHalf, 1'b1, 32'h200, 32'h0, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || rd !== 32'h0000_2233)
      $display("FAIL half_signed_pos: got %h (timeout %0b) want 00002233", rd, to);
    else n_pass++;
  endtask

  task automatic test_half_write();
    logic [31:0] rd;
    logic        er;
    bit          to;
    int          b0;
    mem_word = 32'h1122_3344;
    bus_lat  = 2;
    b0 = n_bus;
    data_xfer(1'b1, WidthHalf, 1'b0, 32'h302, 32'h5555_ABCD, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || er !== 1'b0 || n_bus - b0 !== 2)
      $display("FAIL rmw_done: got err %b txns %0d (timeout %0b) want 0 2", er, n_bus - b0, to);
    else n_pass++;
    n_checks++;
    if (log_rw[b0] !== 1'b0 || log_addr[b0] !== 32'h300)
      $display("FAIL rmw_read: got rw %b addr %h want 0 00000300", log_rw[b0], log_addr[b0]);
    else n_pass++;
    n_checks++;
    if (log_rw[b0+1] !== 1'b1 || log_addr[b0+1] !== 32'h300 || log_wdata[b0+1] !== 32'hABCD_3344)
      $display("FAIL rmw_write: got rw %b addr %h data %h want 1 00000300 abcd3344",
               log_rw[b0+1], log_addr[b0+1], log_wdata[b0+1]);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic        er;
    bit          to;
    int          b0;
    b0 = n_bus;
    data_xfer(1'b0, WidthWord, 1'b0, 32'h401, 32'h0, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || er !== 1'b1)
      $display("FAIL misaligned_err: got err %b (timeout %0b) want 1", er, to);
    else n_pass++;
    data_xfer(1'b1, 3'd3, 1'b0, 32'h400, 32'h0, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || er !== 1'b1)
      $display("FAIL bad_width_err: got err %b (timeout %0b) want 1", er, to);
    else n_pass++;
    wait_cycles(3);
    n_checks++;
    if (n_bus - b0 !== 0)
      $display("FAIL error_no_bus: got %0d bus txns want 0", n_bus - b0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int seen;
    mem_word = 32'h0BAD_F00D;
    bus_lat  = 1;
    order_q.delete();
    seen = 0;
    @(posedge clk);
    #1;
    bif.i_fetch_request = 1'b1;
    bif.i_fetch_address = 32'h700;
    bif.i_data_request  = 1'b1;
    bif.i_data_rw       = 1'b0;
    bif.i_data_width    = WidthWord;
    bif.i_data_signed   = 1'b0;
    bif.i_data_address  = 32'h600;
    for (int i = 0; i < 100 && seen < 4; i++) begin
      @(negedge clk);
      if (bif.o_fetch_ready === 1'b1) seen++;
      if (bif.o_data_ready === 1'b1) seen++;
    end
    bif.i_fetch_request = 1'b0;
    bif.i_data_request  = 1'b0;
    wait_cycles(4);
    n_checks++;
    if (order_q.size() !== 4)
      $display("FAIL alt_count: got %0d completions want 4", order_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < order_q.size(); i++) begin
      n_checks++;
      if (order_q[i] !== ((i % 2 == 0) ? PortData : PortFetch))
        $display("FAIL alt_order[%0d]: got port %0d want %0d", i, order_q[i],
                 (i % 2 == 0) ? PortData : PortFetch);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd;
    logic        er;
    bit          to;
    bit          got_req;
    int          d0, b0;
    mem_word = 32'h1122_3344;
    bus_lat  = 5;
    got_req  = 1'b0;
    @(posedge clk);
    #1;
    bif.i_data_request = 1'b1;
    bif.i_data_rw      = 1'b1;
    bif.i_data_width   = WidthHalf;
    bif.i_data_signed  = 1'b0;
    bif.i_data_address = 32'h302;
    bif.i_data_wdata   = 32'h0000_ABCD;
    for (int i = 0; i < 20 && !got_req; i++) begin
      @(negedge clk);
      if (bif.o_bus_request === 1'b1) got_req = 1'b1;
    end
    n_checks++;
    if (got_req !== 1'b1) $display("FAIL rmw_start: got no bus request want request");
    else n_pass++;
    d0 = data_pulses;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bif.o_bus_request, bif.o_data_ready, bif.o_data_error} !== 3'b0 ||
        bif.o_bus_address !== 32'h0 || bif.o_bus_rw !== 1'b0)
      $display("FAIL midreset_bus: got req %b rdy %b addr %h want 0 0 00000000",
               bif.o_bus_request, bif.o_data_ready, bif.o_bus_address);
    else n_pass++;
    n_checks++;
    if (bif.o_fetch_data !== 32'h0 || bif.o_data_rdata !== 32'h0)
      $display("FAIL midreset_data: got %h/%h want 0/0", bif.o_fetch_data, bif.o_data_rdata);
    else n_pass++;
    bif.i_data_request = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(4);
    n_checks++;
    if (data_pulses - d0 !== 0 || bif.o_bus_request !== 1'b0)
      $display("FAIL midreset_quiet: got pulses %0d req %b want 0 0",
               data_pulses - d0, bif.o_bus_request);
    else n_pass++;
    mem_word = 32'h1234_5678;
    bus_lat  = 1;
    b0 = n_bus;
    data_xfer(1'b0, WidthWord, 1'b0, 32'h500, 32'h0, rd, er, to);
    n_checks++;
    if (to !== 1'b0 || rd !== 32'h1234_5678 || er !== 1'b0)
      $display("FAIL post_reset_read: got %h err %b (timeout %0b) want 12345678 0", rd, er, to);
    else n_pass++;
    n_checks++;
    if (n_bus - b0 !== 1 || log_addr[b0] !== 32'h500 || log_rw[b0] !== 1'b0)
      $display("FAIL post_reset_bus: got %0d txns addr %h rw %b want 1 00000500 0",
               n_bus - b0, log_addr[b0], log_rw[b0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_read();
    test_half_write();
    test_misaligned();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
